piso_tx_framer: RTL and testbench

Parallel-in/serial-out transmit framer that accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled cycle on a serial line, with per-word bit-order select. It sits directly upstream of the 4-bit universal shift register. `sout` drives that register's serial input, and `sout_valid` qualifies its shift select. A one-word pending slot allows back-to-back words with no idle bit between them.

---
 rtl/shift_pkg.sv | 13 +
 rtl/piso_tx_framer.sv | 117 +++++++++++
 tb/tb_piso_tx_framer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared bit-order constants, state type and default word width
package shift_pkg;

    localparam int   DEF_WIDTH = 4;
    localparam logic ORD_MSB   = 1'b0;
    localparam logic ORD_LSB   = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_tx_framer.sv
// piso_tx_framer: valid/ready word intake, one-word pending slot, serial output with per-word bit order
module piso_tx_framer
    import shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_lsb_first,
    input  logic             en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t             r_state, w_nxt_state;
    logic [WIDTH-1:0]   r_shreg, w_nxt_shreg;
    logic               r_ord, w_nxt_ord;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [WIDTH-1:0]   r_pend_data, w_nxt_pend_data;
    logic               r_pend_ord, w_nxt_pend_ord;
    logic               r_pend_full, w_nxt_pend_full;
    logic               w_nxt_sout, w_nxt_valid, w_nxt_last, w_nxt_busy;

    // in_ready is the registered inverse of pend_full, so accept never depends on inputs
    wire w_acc = in_valid && in_ready;
    wire w_adv = (r_state == SHIFT) && en;
    wire w_end = w_adv && (r_cnt == LAST);

    // State and output registers; outputs are computed from next-state so they are flop outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_ord       <= ORD_MSB;
            r_cnt       <= '0;
            r_pend_data <= '0;
            r_pend_ord  <= ORD_MSB;
            r_pend_full <= 1'b0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            sout_last   <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            r_state     <= w_nxt_state;
            r_shreg     <= w_nxt_shreg;
            r_ord       <= w_nxt_ord;
            r_cnt       <= w_nxt_cnt;
            r_pend_data <= w_nxt_pend_data;
            r_pend_ord  <= w_nxt_pend_ord;
            r_pend_full <= w_nxt_pend_full;
            sout        <= w_nxt_sout;
            sout_valid  <= w_nxt_valid;
            sout_last   <= w_nxt_last;
            busy        <= w_nxt_busy;
            in_ready    <= !w_nxt_pend_full;
        end
    end

    // Next state: load from IDLE, reload at end of word (pending first), else shift and park new words
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_shreg     = r_shreg;
        w_nxt_ord       = r_ord;
        w_nxt_cnt       = r_cnt;
        w_nxt_pend_data = r_pend_data;
        w_nxt_pend_ord  = r_pend_ord;
        w_nxt_pend_full = r_pend_full;
        if (r_state == IDLE) begin
            if (w_acc) begin
                w_nxt_state = SHIFT;
                w_nxt_shreg = in_data;
                w_nxt_ord   = in_lsb_first;
                w_nxt_cnt   = '0;
            end
        end else if (w_end) begin
            w_nxt_cnt = '0;
            if (r_pend_full) begin
                w_nxt_shreg     = r_pend_data;
                w_nxt_ord       = r_pend_ord;
                w_nxt_pend_full = 1'b0;
            end else if (w_acc) begin
                w_nxt_shreg = in_data;
                w_nxt_ord   = in_lsb_first;
            end else begin
                w_nxt_state = IDLE;
            end
        end else begin
            if (w_adv) begin
                w_nxt_shreg = (r_ord == ORD_LSB) ? {1'b0, r_shreg[WIDTH-1:1]} : {r_shreg[WIDTH-2:0], 1'b0};
                w_nxt_cnt   = r_cnt + 1'b1;
            end
            if (w_acc) begin
                w_nxt_pend_data = in_data;
                w_nxt_pend_ord  = in_lsb_first;
                w_nxt_pend_full = 1'b1;
            end
        end
    end

    // Output decode of the next state; sout is forced low whenever no word bit is presented
    always_comb begin
        w_nxt_valid = (w_nxt_state == SHIFT);
        w_nxt_sout  = w_nxt_valid && ((w_nxt_ord == ORD_LSB) ? w_nxt_shreg[0] : w_nxt_shreg[WIDTH-1]);
        w_nxt_last  = w_nxt_valid && (w_nxt_cnt == LAST);
        w_nxt_busy  = w_nxt_valid || w_nxt_pend_full;
    end

endmodule

// File: tb/tb_piso_tx_framer.sv
// tb_piso_tx_framer: directed vectors with hand-computed serial streams for piso_tx_framer
module tb_piso_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'b0;
    logic       in_lsb_first = 1'b0;
    logic       en = 1'b1;
    logic       sout, sout_valid, sout_last, busy;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    piso_tx_framer #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_lsb_first (in_lsb_first),
        .en           (en),
        .sout         (sout),
        .sout_valid   (sout_valid),
        .sout_last    (sout_last),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word was accepted
    task automatic drive(input logic [3:0] d, input logic lsb);
        logic rdy;
        int   t;
        in_valid     = 1'b1;
        in_data      = d;
        in_lsb_first = lsb;
        rdy = in_ready;
        t = 0;
        while (!rdy && t < 32) begin
            @(negedge clk);
            rdy = in_ready;
            t++;
        end
        if (!rdy) check("drive_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    // seq holds the expected transmit order, first bit in seq[3]
    task automatic expect_word(input string tag, input logic [3:0] seq);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_sout"}, 32'(sout), 32'(seq[3-i]));
            check({tag, "_valid"}, 32'(sout_valid), 32'd1);
            check({tag, "_last"}, 32'(sout_last), 32'(i == 3));
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_idle_valid"}, 32'(sout_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_valid", 32'(sout_valid), 32'd0);
        check("rst_last", 32'(sout_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_rst0");

        drive(4'b1011, 1'b0);
        in_valid = 1'b0;
        expect_word("msb", 4'b1011);
        check_idle("msb");

        en = 1'b0;
        drive(4'b1011, 1'b1);
        in_valid = 1'b0;
        en = 1'b1;
        expect_word("lsb", 4'b1101);
        check_idle("lsb");

        fork
            begin
                drive(4'b1100, 1'b0);
                drive(4'b0011, 1'b0);
                drive(4'b1111, 1'b0);
                in_valid = 1'b0;
            end
            begin
                logic [11:0] stream;
                stream = 12'b1100_0011_1111;
                @(negedge clk);
                for (int i = 0; i < 12; i++) begin
                    check("b2b_sout", 32'(sout), 32'(stream[11-i]));
                    check("b2b_valid", 32'(sout_valid), 32'd1);
                    check("b2b_last", 32'(sout_last), 32'(i % 4 == 3));
                    check("b2b_ready", 32'(in_ready), 32'(i == 0 || i == 4 || i >= 8));
                    @(negedge clk);
                end
            end
        join
        check_idle("b2b");

        drive(4'b1010, 1'b0);
        in_valid = 1'b0;
        check("stall_b1", 32'(sout), 32'd1);
        @(negedge clk);
        check("stall_b2", 32'(sout), 32'd0);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_hold_sout", 32'(sout), 32'd0);
            check("stall_hold_valid", 32'(sout_valid), 32'd1);
            check("stall_hold_last", 32'(sout_last), 32'd0);
        end
        en = 1'b1;
        @(negedge clk);
        check("stall_b3", 32'(sout), 32'd1);
        check("stall_b3_last", 32'(sout_last), 32'd0);
        @(negedge clk);
        check("stall_b4", 32'(sout), 32'd0);
        check("stall_b4_last", 32'(sout_last), 32'd1);
        @(negedge clk);
        check_idle("stall");

        drive(4'b1100, 1'b0);
        drive(4'b0101, 1'b0);
        in_valid = 1'b0;
        check("mid_b2", 32'(sout), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_pend_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sout", 32'(sout), 32'd0);
        check("mid_rst_valid", 32'(sout_valid), 32'd0);
        check("mid_rst_last", 32'(sout_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_idle("mid_release");
        end
        drive(4'b0110, 1'b1);
        in_valid = 1'b0;
        expect_word("post_rst", 4'b0110);
        check_idle("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
